// File: rtl/pipe_trace_buffer_if.sv
// Trace readout port: one buffer entry per valid/ready transfer, oldest first.
interface pipe_trace_buffer_if #(
    parameter int DW = 160
);
    logic          rd_valid;
    logic          rd_ready;
    logic [DW-1:0] rd_data;
    logic          rd_last;

    modport master (output rd_valid, output rd_data, output rd_last, input rd_ready);
    modport slave  (input rd_valid, input rd_data, input rd_last, output rd_ready);
endinterface

// File: rtl/pipe_trace_buffer.sv
// Circular trace of {pc, stage instructions}; freezes POST_TRIG entries after a trigger,
// then streams the frozen window out oldest-first.
module pipe_trace_buffer #(
    parameter int NSTAGES   = 4,
    parameter int IW        = 32,
    parameter int PCW       = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     cap_en,
    input  logic [PCW-1:0]           pc,
    input  logic [NSTAGES*IW-1:0]    stage_instr,
    input  logic                     arm,
    input  logic                     force_trig,
    input  logic [3:0]               trig_op,
    input  logic                     trig_op_en,
    input  logic [PCW-1:0]           trig_pc,
    input  logic                     trig_pc_en,
    pipe_trace_buffer_if.master      rd,
    output logic [1:0]               state,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = PCW + NSTAGES * IW;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] POST_N  = CW'(POST_TRIG);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_POST, S_DONE} st_t;

    st_t           st, st_n;
    logic [AW-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
    logic [CW-1:0] cnt, cnt_n, rem, rem_n, post_cnt, post_cnt_n;
    logic          we, trig_hit, xfer;
    logic [DW-1:0] mem [DEPTH];

    assign trig_hit = force_trig ||
                      ((trig_op_en || trig_pc_en) &&
                       (!trig_op_en || stage_instr[24:21] == trig_op) &&
                       (!trig_pc_en || pc == trig_pc));
    assign xfer = rd.rd_valid && rd.rd_ready;

    always_comb begin
        st_n       = st;
        wr_ptr_n   = wr_ptr;
        cnt_n      = cnt;
        post_cnt_n = post_cnt;
        rd_ptr_n   = rd_ptr;
        rem_n      = rem;
        we         = 1'b0;
        // arm overrides any capture, trigger or transfer in the same cycle
        if (arm) begin
            st_n       = S_ARMED;
            wr_ptr_n   = '0;
            cnt_n      = '0;
            post_cnt_n = '0;
            rem_n      = '0;
        end else begin
            case (st)
                S_ARMED, S_POST: begin
                    if (cap_en) begin
                        we       = 1'b1;
                        wr_ptr_n = wr_ptr + AW'(1);
                        if (cnt != DEPTH_C) cnt_n = cnt + CW'(1);
                        if (st == S_ARMED) begin
                            if (trig_hit) begin
                                post_cnt_n = '0;
                                st_n       = (POST_TRIG == 0) ? S_DONE : S_POST;
                            end
                        end else begin
                            post_cnt_n = post_cnt + CW'(1);
                            if (post_cnt + CW'(1) == POST_N) st_n = S_DONE;
                        end
                        // oldest held entry; when full this equals the new wr_ptr
                        if (st_n == S_DONE) begin
                            rd_ptr_n = wr_ptr_n - cnt_n[AW-1:0];
                            rem_n    = cnt_n;
                        end
                    end
                end
                S_DONE: begin
                    if (xfer) begin
                        rd_ptr_n = rd_ptr + AW'(1);
                        rem_n    = rem - CW'(1);
                        if (rem == CW'(1)) st_n = S_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st       <= S_IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            rem      <= '0;
            post_cnt <= '0;
        end else begin
            st       <= st_n;
            wr_ptr   <= wr_ptr_n;
            rd_ptr   <= rd_ptr_n;
            cnt      <= cnt_n;
            rem      <= rem_n;
            post_cnt <= post_cnt_n;
        end
    end

    always_ff @(posedge clk) begin
        if (we) mem[wr_ptr] <= {pc, stage_instr};
    end

    assign rd.rd_valid = (st == S_DONE);
    assign rd.rd_last  = rd.rd_valid && (rem == CW'(1));
    assign rd.rd_data  = rd.rd_valid ? mem[rd_ptr] : '0;
    assign state       = st;
    assign count       = cnt;
endmodule

// File: tb/tb_pipe_trace_buffer.sv
// Directed bench for pipe_trace_buffer: capture, trigger, wrap, backpressure, gating, precedence, reset.
module tb_pipe_trace_buffer;
    localparam int NSTAGES = 4;
    localparam int IW      = 32;
    localparam int PCW     = 32;
    localparam int DEPTH   = 16;
    localparam int DW      = PCW + NSTAGES * IW;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic                  cap_en, arm, force_trig, trig_op_en, trig_pc_en;
    logic [PCW-1:0]        pc, trig_pc;
    logic [NSTAGES*IW-1:0] stage_instr;
    logic [3:0]            trig_op;
    logic [1:0]            state;
    logic [$clog2(DEPTH):0] count;

    int n_chk  = 0;
    int n_pass = 0;

    pipe_trace_buffer_if #(.DW(DW)) rd_if ();

    pipe_trace_buffer #(
        .NSTAGES(NSTAGES), .IW(IW), .PCW(PCW), .DEPTH(DEPTH), .POST_TRIG(8)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cap_en(cap_en), .pc(pc), .stage_instr(stage_instr),
        .arm(arm), .force_trig(force_trig), .trig_op(trig_op), .trig_op_en(trig_op_en),
        .trig_pc(trig_pc), .trig_pc_en(trig_pc_en), .rd(rd_if.master),
        .state(state), .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Entry i: pc=4*i; stage k word = {k, 0, op (stage0) or F, pc[20:0]}
    function automatic logic [DW-1:0] ent(input int i, input logic [3:0] op);
        logic [PCW-1:0]        p;
        logic [NSTAGES*IW-1:0] si;
        p  = PCW'(4 * i);
        si = '0;
        for (int k = 0; k < NSTAGES; k++)
            si[k*IW +: IW] = {3'(k), 4'h0, (k == 0) ? op : 4'hF, p[20:0]};
        return {p, si};
    endfunction

    task automatic cap(input int i, input logic [3:0] op, input logic frc);
        logic [DW-1:0] e;
        e = ent(i, op);
        pc          = e[DW-1 -: PCW];
        stage_instr = e[NSTAGES*IW-1:0];
        cap_en      = 1'b1;
        force_trig  = frc;
        @(negedge clk);
        cap_en     = 1'b0;
        force_trig = 1'b0;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic rd_win(input int n, input int first, input int trig, input int total);
        for (int j = 0; j < n; j++) begin
            int i;
            i = first + j;
            chk("rd_valid", rd_if.rd_valid, 1);
            chk("rd_data", rd_if.rd_data, ent(i, (i == trig) ? 4'h4 : 4'h1));
            chk("rd_last", rd_if.rd_last, (j == total - 1));
            rd_if.rd_ready = 1'b1;
            @(negedge clk);
            rd_if.rd_ready = 1'b0;
        end
        if (n == total) begin
            chk("end_state", state, 0);
            chk("end_valid", rd_if.rd_valid, 0);
        end
    endtask

    initial begin
        reset_n = 1'b0; cap_en = 0; arm = 0; force_trig = 0; trig_op_en = 0; trig_pc_en = 0;
        pc = '0; trig_pc = '0; stage_instr = '0; trig_op = '0; rd_if.rd_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_state", state, 0);
        chk("rst_count", count, 0);
        chk("rst_valid", rd_if.rd_valid, 0);
        chk("rst_last", rd_if.rd_last, 0);
        chk("rst_data", rd_if.rd_data, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // T2: 5 pre, forced trigger on pc=20, 8 post -> 14 entries pc 0..52
        do_arm();
        chk("t2_armed", state, 1);
        chk("t2_cnt0", count, 0);
        for (int i = 0; i < 5; i++) cap(i, 4'h1, 1'b0);
        chk("t2_pre_state", state, 1);
        chk("t2_pre_cnt", count, 5);
        cap(5, 4'h1, 1'b1);
        chk("t2_post_state", state, 2);
        for (int i = 6; i < 14; i++) cap(i, 4'h1, 1'b0);
        chk("t2_done", state, 3);
        chk("t2_count", count, 14);
        rd_win(14, 0, -1, 14);

        // T3: wrap, opcode trigger at i=20 -> window i=13..28
        trig_op = 4'b0100; trig_op_en = 1'b1;
        do_arm();
        for (int i = 0; i < 30; i++) cap(i, (i == 20) ? 4'h4 : 4'h1, 1'b0);
        trig_op_en = 1'b0;
        chk("t3_done", state, 3);
        chk("t3_count", count, 16);
        rd_win(16, 13, 20, 16);

        // T4: backpressure with rd_ready 1,0,0,1
        do_arm();
        for (int i = 0; i < 12; i++) cap(i, 4'h1, (i == 3));
        chk("t4_done", state, 3);
        chk("t4_count", count, 12);
        chk("t4_d0", rd_if.rd_data, ent(0, 4'h1));
        rd_if.rd_ready = 1'b1; @(negedge clk);
        chk("t4_d1a", rd_if.rd_data, ent(1, 4'h1));
        rd_if.rd_ready = 1'b0; @(negedge clk);
        chk("t4_d1b", rd_if.rd_data, ent(1, 4'h1));
        @(negedge clk);
        chk("t4_d1c", rd_if.rd_data, ent(1, 4'h1));
        rd_if.rd_ready = 1'b1; @(negedge clk);
        rd_if.rd_ready = 1'b0;
        rd_win(10, 2, -1, 10);

        // T5: cap_en low in POST freezes progress
        do_arm();
        for (int i = 0; i < 4; i++) cap(i, 4'h1, (i == 2));
        chk("t5_post", state, 2);
        force_trig = 1'b1;
        for (int c = 0; c < 10; c++) begin
            pc = PCW'(1000 + c);
            @(negedge clk);
        end
        force_trig = 1'b0;
        chk("t5_hold_state", state, 2);
        chk("t5_hold_cnt", count, 4);
        for (int i = 4; i < 10; i++) cap(i, 4'h1, 1'b0);
        chk("t5_not_done", state, 2);
        cap(10, 4'h1, 1'b0);
        chk("t5_done", state, 3);
        chk("t5_count", count, 11);
        rd_win(11, 0, -1, 11);

        // T6: arm beats a same-cycle PC hit; arm during readout discards
        do_arm();
        cap(0, 4'h1, 1'b0);
        cap(1, 4'h1, 1'b0);
        trig_pc = 32'd8; trig_pc_en = 1'b1;
        arm = 1'b1;
        cap(2, 4'h1, 1'b0);
        arm = 1'b0;
        chk("t6_armed", state, 1);
        chk("t6_cnt0", count, 0);
        for (int i = 2; i < 11; i++) cap(i, 4'h1, 1'b0);
        trig_pc_en = 1'b0;
        chk("t6_done", state, 3);
        chk("t6_count", count, 9);
        rd_win(3, 2, -1, 9);
        do_arm();
        chk("t6_rearm", state, 1);
        chk("t6_recnt", count, 0);
        chk("t6_revalid", rd_if.rd_valid, 0);

        // T1: async reset mid-POST, then IDLE ignores captures
        cap(0, 4'h1, 1'b1);
        cap(1, 4'h1, 1'b0);
        chk("t1_post", state, 2);
        #2 reset_n = 1'b0;
        #1;
        chk("t1_rst_state", state, 0);
        chk("t1_rst_count", count, 0);
        chk("t1_rst_valid", rd_if.rd_valid, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) cap(i, 4'h1, 1'b1);
        chk("t1_idle_state", state, 0);
        chk("t1_idle_count", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
